// File: rtl/fb_pkg.sv
// Shared types for the framebuffer write arbiter.
// No logic; enum only.
// No flow control here.
package fb_pkg;

  // Arbiter FSM: serve requesters, fill memory, report fill completion.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a "last granted" pointer.
// Grant is combinational (0 cycles); pointer moves one cycle after advance.
// No backpressure of its own; caller qualifies grant into ready.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // On a tie, favour the requester that did not win last; a lone requester always wins.
  always_comb begin
    grant  = valid;
    last_d = last_q;
    if (valid == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    if (advance) begin
      last_d = grant[1];
    end
  end

  // Pointer starts as "requester 1 last", so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Arbitrates two write requesters onto one memory write port; also fills the memory on request.
// Latency 1: accepted write or fill word appears registered on mem_* the next enabled cycle.
// Readies drop during a fill, while clk_en is low, and on the cycle clear_start is accepted.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             req0_valid,
  input  logic [ADDRW-1:0] req0_addr,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [ADDRW-1:0] req1_addr,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             clear_start,
  input  logic [WIDTH-1:0] clear_value,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             busy,
  output logic             clear_done
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  fb_state_e        state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] fill_q, fill_d;
  logic             we_q, we_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [1:0] grant;
  logic       accept_ok;
  logic       hs0;
  logic       hs1;

  // A clear request in the same cycle wins over both requesters.
  assign accept_ok  = clk_en & (state_q == RUN) & ~clear_start;
  assign req0_ready = grant[0] & accept_ok;
  assign req1_ready = grant[1] & accept_ok;
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (hs0 | hs1),
    .grant   (grant)
  );

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign busy       = (state_q != RUN);
  assign clear_done = (state_q == DONE) & clk_en;

  // Next state and next write-port values; with clk_en low everything holds and no write issues.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clk_en) begin
      case (state_q)
        RUN: begin
          if (clear_start) begin
            fill_d  = clear_value;
            cnt_d   = '0;
            state_d = CLEAR;
          end else if (hs0) begin
            we_d   = 1'b1;
            addr_d = req0_addr;
            data_d = req0_data;
          end else if (hs1) begin
            we_d   = 1'b1;
            addr_d = req1_addr;
            data_d = req1_data;
          end
        end
        CLEAR: begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          data_d = fill_q;
          // Stop on the last real address so non-power-of-2 depths never overrun.
          if (cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ADDRW'(1);
          end
        end
        DONE: begin
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // State and registered write port; reset wins over clk_en and aborts any fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      fill_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter (WIDTH=8, DEPTH=16).
// Inputs change on negedge; outputs sampled at negedge (+#1 for combinational readies).
// Clear scenarios are bounded loops that stop when busy falls.
module tb_fb_write_arbiter;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic       req0_valid;
  logic [3:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       clear_start;
  logic [7:0] clear_value;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       clear_done;

  int vectors;
  int miscompares;

  fb_write_arbiter #(.WIDTH(8), .DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; clear_start = 1'b0; clear_value = 8'h00;
    req0_valid = 1'b0; req0_addr = 4'd0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_addr = 4'd0; req1_data = 8'h00;
    repeat (2) @(negedge clk);
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 4'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
    vectors++; if (mem_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %0h want 0", mem_data); end
    vectors++; if (busy !== 1'b0 || clear_done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done: got %b%b want 00", busy, clear_done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 4'd3; req0_data = 8'hA5;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready0: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd3 || mem_data !== 8'hA5) begin
      miscompares++; $display("FAIL single_write: got we=%b a=%0d d=%0h want we=1 a=3 d=a5", mem_we, mem_addr, mem_data); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0 || mem_addr !== 4'd3 || mem_data !== 8'hA5) begin
      miscompares++; $display("FAIL idle_hold: got we=%b a=%0d d=%0h want we=0 a=3 d=a5", mem_we, mem_addr, mem_data); end
    // Pointer now says req0 last; a lone req1 must still be granted.
    req1_valid = 1'b1; req1_addr = 4'd12; req1_data = 8'h77;
    #1;
    vectors++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      miscompares++; $display("FAIL single_ready1: got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd12 || mem_data !== 8'h77) begin
      miscompares++; $display("FAIL single_write1: got we=%b a=%0d d=%0h want we=1 a=12 d=77", mem_we, mem_addr, mem_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_addr [4];
    exp_addr[0] = 4'd1; exp_addr[1] = 4'd2; exp_addr[2] = 4'd1; exp_addr[3] = 4'd2;
    req0_valid = 1'b1; req0_addr = 4'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        miscompares++; $display("FAIL rr_grant%0d: got r0=%b r1=%b want r0=%b r1=%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1)); end
      @(negedge clk);
      vectors++; if (mem_we !== 1'b1 || mem_addr !== exp_addr[i]) begin
        miscompares++; $display("FAIL rr_addr%0d: got we=%b a=%0d want we=1 a=%0d", i, mem_we, mem_addr, exp_addr[i]); end
    end
    // Hold both valid with clk_en low: nothing accepted, pointer must not move.
    clk_en = 1'b0;
    #1;
    vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL en_low_ready: got r0=%b r1=%b want 00", req0_ready, req1_ready); end
    @(negedge clk);
    vectors++; if (mem_we !== 1'b0 || mem_addr !== 4'd2 || mem_data !== 8'h22) begin
      miscompares++; $display("FAIL en_low_hold: got we=%b a=%0d d=%0h want we=0 a=2 d=22", mem_we, mem_addr, mem_data); end
    clk_en = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL en_resume_grant: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd1) begin
      miscompares++; $display("FAIL en_resume_write: got we=%b a=%0d want we=1 a=1", mem_we, mem_addr); end
  endtask

  task automatic test_clear();
    int busy_n = 0;
    int wr_n = 0;
    int done_n = 0;
    bit fin = 1'b0;
    req1_valid = 1'b1; req1_addr = 4'd4; req1_data = 8'h99;
    clear_value = 8'h00; clear_start = 1'b1;
    #1;
    vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL clear_start_ready1: got %b want 0", req1_ready); end
    @(negedge clk);
    clear_start = 1'b0; clear_value = 8'hEE;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (busy) begin
        busy_n++;
        vectors++; if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL clear_ready1_k%0d: got %b want 0", k, req1_ready); end
      end
      if (mem_we) begin
        vectors++; if (mem_addr !== 4'(wr_n) || mem_data !== 8'h00) begin
          miscompares++; $display("FAIL clear_write%0d: got a=%0d d=%0h want a=%0d d=0", wr_n, mem_addr, mem_data, wr_n); end
        wr_n++;
      end
      if (clear_done) done_n++;
      clear_start = (k == 4);
      if (!busy) fin = 1'b1;
      else @(negedge clk);
    end
    req1_valid = 1'b0; clear_start = 1'b0;
    vectors++; if (!fin) begin miscompares++; $display("FAIL clear_timeout: got busy=%b want 0 within 40 cycles", busy); end
    vectors++; if (busy_n != 17) begin miscompares++; $display("FAIL clear_busy_len: got %0d want 17", busy_n); end
    vectors++; if (wr_n != 16) begin miscompares++; $display("FAIL clear_writes: got %0d want 16", wr_n); end
    vectors++; if (done_n != 1) begin miscompares++; $display("FAIL clear_done_pulses: got %0d want 1", done_n); end
    @(negedge clk);
  endtask

  task automatic test_clear_vs_req();
    int wr_n = 0;
    bit fin = 1'b0;
    req0_valid = 1'b1; req0_addr = 4'd7; req0_data = 8'h3C;
    clear_value = 8'h0F; clear_start = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL collide_ready0: got %b want 0", req0_ready); end
    @(negedge clk);
    clear_start = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      if (busy) begin
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL collide_busy_ready0_k%0d: got %b want 0", k, req0_ready); end
      end
      if (mem_we) begin
        vectors++; if (mem_data !== 8'h0F) begin miscompares++; $display("FAIL collide_fill_data: got %0h want 0f", mem_data); end
        wr_n++;
      end
      if (!busy) fin = 1'b1;
      else @(negedge clk);
    end
    vectors++; if (!fin || wr_n != 16) begin miscompares++; $display("FAIL collide_clear: got fin=%b writes=%0d want fin=1 writes=16", fin, wr_n); end
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL collide_after_ready0: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd7 || mem_data !== 8'h3C) begin
      miscompares++; $display("FAIL collide_req_write: got we=%b a=%0d d=%0h want we=1 a=7 d=3c", mem_we, mem_addr, mem_data); end
  endtask

  task automatic test_clear_stall();
    int wr_n = 0;
    bit fin = 1'b0;
    bit paused = 1'b0;
    clear_value = 8'h5A; clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    for (int k = 0; k < 60 && !fin; k++) begin
      if (mem_we) begin
        vectors++; if (mem_addr !== 4'(wr_n) || mem_data !== 8'h5A) begin
          miscompares++; $display("FAIL stall_write%0d: got a=%0d d=%0h want a=%0d d=5a", wr_n, mem_addr, mem_data, wr_n); end
        wr_n++;
        if (mem_addr == 4'd5 && !paused) begin
          paused = 1'b1;
          clk_en = 1'b0;
          for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            vectors++; if (mem_we !== 1'b0 || mem_addr !== 4'd5 || clear_done !== 1'b0 || busy !== 1'b1) begin
              miscompares++; $display("FAIL stall_hold%0d: got we=%b a=%0d done=%b busy=%b want we=0 a=5 done=0 busy=1", j, mem_we, mem_addr, clear_done, busy); end
          end
          clk_en = 1'b1;
        end
      end
      if (!busy) fin = 1'b1;
      else @(negedge clk);
    end
    vectors++; if (!paused || !fin || wr_n != 16) begin
      miscompares++; $display("FAIL stall_total: got paused=%b fin=%b writes=%0d want 1 1 16", paused, fin, wr_n); end
  endtask

  task automatic test_clear_reset();
    bit hit = 1'b0;
    int bad = 0;
    clear_value = 8'hFF; clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (mem_we && mem_addr == 4'd9) begin
        hit = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL rst_reach_addr9: got no write to 9 want one"); end
    vectors++; if (busy !== 1'b0 || mem_we !== 1'b0 || clear_done !== 1'b0 || mem_addr !== 4'd0) begin
      miscompares++; $display("FAIL rst_midclear: got busy=%b we=%b done=%b a=%0d want 0 0 0 0", busy, mem_we, clear_done, mem_addr); end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (clear_done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL rst_no_resume: got %0d bad cycles want 0", bad); end
    req0_valid = 1'b1; req0_addr = 4'd10; req0_data = 8'h42;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL rst_run_ready0: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 4'd10 || mem_data !== 8'h42) begin
      miscompares++; $display("FAIL rst_run_write: got we=%b a=%0d d=%0h want we=1 a=10 d=42", mem_we, mem_addr, mem_data); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_clear();
    test_clear_vs_req();
    test_clear_stall();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
